// File: rtl/serial_mag_comparator_if.sv
// rtl/serial_mag_comparator_if.sv - operand request and result bundle for the serial magnitude comparator
interface serial_mag_comparator_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             smaller;
    logic             equal;
    logic             greater;

    modport master (
        output start, a, b,
        input  busy, done, smaller, equal, greater
    );

    modport slave (
        input  start, a, b,
        output busy, done, smaller, equal, greater
    );
endinterface

// File: rtl/serial_mag_comparator.sv
// rtl/serial_mag_comparator.sv - bit-serial MSB-first unsigned magnitude comparator
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    reset,
    serial_mag_comparator_if.slave cmp
);
    localparam int IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [IDX_W-1:0] idx;
    logic             busy_q;
    logic             done_q;
    logic             smaller_q;
    logic             equal_q;
    logic             greater_q;

    // Capture operands on start, then examine one bit per cycle from the MSB down.
    // The first differing bit decides the result; the walk ends at bit 0 without wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            smaller_q <= 1'b0;
            equal_q   <= 1'b0;
            greater_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmp.start) begin
                        a_q       <= cmp.a;
                        b_q       <= cmp.b;
                        idx       <= IDX_W'(WIDTH - 1);
                        smaller_q <= 1'b0;
                        equal_q   <= 1'b0;
                        greater_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (a_q[idx] != b_q[idx]) begin
                        greater_q <= a_q[idx];
                        smaller_q <= ~a_q[idx];
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state     <= IDLE;
                    end else if (idx == '0) begin
                        equal_q <= 1'b1;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmp.busy    = busy_q;
    assign cmp.done    = done_q;
    assign cmp.smaller = smaller_q;
    assign cmp.equal   = equal_q;
    assign cmp.greater = greater_q;
endmodule

// File: tb/tb_serial_mag_comparator.sv
// tb/tb_serial_mag_comparator.sv - self-checking bench for the serial magnitude comparator
module tb_serial_mag_comparator;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    serial_mag_comparator_if #(.WIDTH(W)) cif ();

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .cmp   (cif.slave)
    );

    always #5 clk = ~clk;

    // Reference: 0 = smaller, 1 = equal, 2 = greater
    function automatic int ref_rel(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x < y) return 0;
        if (x == y) return 1;
        return 2;
    endfunction

    // Reference: cycles from acceptance to done, W - (highest differing bit)
    function automatic int ref_latency(input logic [W-1:0] x, input logic [W-1:0] y);
        int diff;
        if (x == y) return W;
        diff = int'(x ^ y);
        return W - ($clog2(diff + 1) - 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag, input int rel);
        check({tag, "_smaller"}, 32'(cif.smaller), 32'(rel == 0));
        check({tag, "_equal"},   32'(cif.equal),   32'(rel == 1));
        check({tag, "_greater"}, 32'(cif.greater), 32'(rel == 2));
    endtask

    task automatic start_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        cif.start = 1'b1;
        cif.a     = x;
        cif.b     = y;
        tick();
        cif.start = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(cif.busy), 32'd1);
        check({tag, "_done_after_accept"}, 32'(cif.done), 32'd0);
        check({tag, "_cleared"}, {29'd0, cif.smaller, cif.equal, cif.greater}, 32'd0);
    endtask

    // Waits for done; when disturb is set, a start with FF/00 is pulsed in the
    // first busy cycle and the operand inputs are scrambled every cycle.
    task automatic wait_done(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                             input bit disturb);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 2 * W + 4) begin
            if (disturb) begin
                cif.start = (n == 0);
                cif.a     = (n == 0) ? 8'hFF : W'($urandom);
                cif.b     = (n == 0) ? 8'h00 : W'($urandom);
            end
            tick();
            n++;
            if (cif.done) seen = 1'b1;
            else check({tag, "_busy_while_running"}, 32'(cif.busy), 32'd1);
        end
        cif.start = 1'b0;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(n), 32'(ref_latency(x, y)));
        check({tag, "_busy_at_done"}, 32'(cif.busy), 32'd0);
        check_results(tag, ref_rel(x, y));
    endtask

    task automatic check_hold(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                              input int cycles);
        for (int i = 0; i < cycles; i++) begin
            cif.a = W'($urandom);
            cif.b = W'($urandom);
            tick();
            check({tag, "_done_single"}, 32'(cif.done), 32'd0);
            check({tag, "_idle"}, 32'(cif.busy), 32'd0);
            check_results({tag, "_hold"}, ref_rel(x, y));
        end
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] pa;
        logic [W-1:0] pb;
        bit           chained;

        reset     = 1'b1;
        cif.start = 1'b0;
        cif.a     = '0;
        cif.b     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_busy", 32'(cif.busy), 32'd0);
        check("reset_done", 32'(cif.done), 32'd0);
        check_results("reset", 3);

        // Equal operands walk all bits
        start_op("eq_a5", 8'hA5, 8'hA5);
        wait_done("eq_a5", 8'hA5, 8'hA5, 1'b0);
        check_hold("eq_a5", 8'hA5, 8'hA5, 2);

        // MSB difference resolves in one cycle
        start_op("msb", 8'h80, 8'h7F);
        wait_done("msb", 8'h80, 8'h7F, 1'b0);
        check_hold("msb", 8'h80, 8'h7F, 3);

        // LSB difference
        start_op("lsb", 8'h12, 8'h13);
        wait_done("lsb", 8'h12, 8'h13, 1'b0);
        check_hold("lsb", 8'h12, 8'h13, 1);

        // Start and operand changes while busy are ignored
        start_op("busy_ign", 8'h0F, 8'h1F);
        wait_done("busy_ign", 8'h0F, 8'h1F, 1'b1);
        check_hold("busy_ign", 8'h0F, 8'h1F, 2);

        // Reset mid-operation aborts, with priority over start
        start_op("abort", 8'h01, 8'h00);
        tick();
        tick();
        reset     = 1'b1;
        cif.start = 1'b1;
        cif.a     = 8'h55;
        cif.b     = 8'hAA;
        tick();
        reset     = 1'b0;
        cif.start = 1'b0;
        check("abort_busy", 32'(cif.busy), 32'd0);
        check("abort_done", 32'(cif.done), 32'd0);
        check_results("abort", 3);
        for (int i = 0; i < W + 2; i++) begin
            tick();
            check("abort_no_done", 32'(cif.done), 32'd0);
        end
        start_op("post_abort", 8'h01, 8'h00);
        wait_done("post_abort", 8'h01, 8'h00, 1'b0);
        check_hold("post_abort", 8'h01, 8'h00, 1);

        // Back-to-back: start held in the done cycle is accepted
        start_op("b2b_first", 8'hC0, 8'h40);
        wait_done("b2b_first", 8'hC0, 8'h40, 1'b0);
        start_op("b2b_second", 8'h00, 8'h00);
        wait_done("b2b_second", 8'h00, 8'h00, 1'b0);
        check_hold("b2b_second", 8'h00, 8'h00, 1);

        // Randomized operations, sometimes chained in the done cycle
        chained = 1'b0;
        pa = '0;
        pb = '0;
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            if (!chained && i > 0) check_hold("rnd_prev", pa, pb, 1);
            start_op("rnd", ra, rb);
            wait_done("rnd", ra, rb, bit'($urandom_range(0, 4) == 0));
            pa = ra;
            pb = rb;
            chained = bit'($urandom_range(0, 1));
        end
        check_hold("rnd_last", pa, pb, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
